fifo_rd_stream: RTL

Read-side drain stage that sits directly downstream of the asynchronous FIFO in the `clk_rd` domain. It issues `fifo_rd_en` against the FIFO's `empty` flag and captures the one-cycle-latency `data_out`. It re-presents the words as a valid/ready stream through a small output buffer, sustaining one word per cycle without ever over-reading. It also counts delivered words and supports a synchronous flush.

---
 rtl/fifo_rd_stream.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain for an async FIFO: issues reads against empty, captures the
// one-cycle-latency data and re-presents it as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  localparam int AW = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic [AW:0]           occ;
  logic                  pend;
  logic                  discard;
  logic                  pop;
  logic                  push;
  logic [AW+1:0]         level;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign push    = pend && !discard;
  assign busy    = m_valid || pend;
  assign m_data  = m_valid ? mem[rd_idx] : '0;

  // Occupancy the buffer will have once everything already committed lands;
  // widened so occ + pend cannot wrap.
  assign level = {1'b0, occ} + {{(AW+1){1'b0}}, pend} - {{(AW+1){1'b0}}, pop};

  assign fifo_rd_en = rst_n && !fifo_empty && !flush && !discard &&
                      (level < (AW+2)'(BUF_DEPTH));

  // Storage is deliberately not reset; m_data is masked while the buffer is empty.
  always_ff @(posedge clk_rd) begin
    if (push && !flush) begin
      mem[wr_idx] <= fifo_data;
    end
  end

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      pend    <= 1'b0;
      discard <= 1'b0;
    end else if (flush) begin
      occ     <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      discard <= pend;
      pend    <= 1'b0;
    end else begin
      discard <= 1'b0;
      pend    <= fifo_rd_en;
      if (push) begin
        wr_idx <= wr_idx + AW'(1);
      end
      if (pop) begin
        rd_idx <= rd_idx + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // A handshake completed in the flush cycle still counts as delivered.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
    end else if (pop && (rd_count != '1)) begin
      rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

endmodule
